// File: rtl/seq_divider_if.sv
// Start/operand/result bundle between the control unit and seq_divider.
// Optional div_unsigned signal exists only when SEQ_DIVIDER_UNSIGNED_EN is defined.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div_init;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  logic             div_unsigned;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output div_init, dividend, divisor,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    output div_unsigned,
`endif
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  div_init, dividend, divisor,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    input  div_unsigned,
`endif
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/seq_divider.sv
// Multicycle restoring divider for MIPS DIV: remainder to hi, quotient to lo.
// SEQ_DIVIDER_UNSIGNED_EN adds div_unsigned for DIVU behaviour.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave dif
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic             sq_q, sr_q;
  logic             busy_q, done_q, zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             use_sign;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign use_sign = ~dif.div_unsigned;
`else
  assign use_sign = 1'b1;
`endif

  always_comb begin
    a_neg = use_sign & dif.dividend[WIDTH-1];
    b_neg = use_sign & dif.divisor[WIDTH-1];
    a_mag = a_neg ? -dif.dividend : dif.dividend;
    b_mag = b_neg ? -dif.divisor  : dif.divisor;
  end

  // Shifted remainder carries an extra bit so the compare never overflows.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_d = WIDTH'(rem_sh - {1'b0, dvs_q});
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      zero_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dif.div_init) begin
            if (dif.divisor == '0) begin
              zero_q <= 1'b1;
            end else begin
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              rem_q   <= '0;
              sq_q    <= a_neg ^ b_neg;
              sr_q    <= a_neg;
              cnt_q   <= CW'(WIDTH - 1);
              busy_q  <= 1'b1;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= SIGN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SIGN: begin
          lo_q    <= sq_q ? -quo_q : quo_q;
          hi_q    <= sr_q ? -rem_q : rem_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dif.busy     = busy_q;
  assign dif.done     = done_q;
  assign dif.div_zero = zero_q;
  assign dif.hi       = hi_q;
  assign dif.lo       = lo_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
// Unsigned cases are compiled in only with SEQ_DIVIDER_UNSIGNED_EN.
module tb_seq_divider;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic uns, output logic [W-1:0] q,
                                output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    if (uns) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[W-1:0];
      r  = lr[W-1:0];
    end
  endfunction

  task automatic set_uns(input logic uns);
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    dif.div_unsigned = uns;
`else
    if (uns) $display("unsigned request ignored in signed-only build");
`endif
  endtask

  // Start one division and follow it cycle by cycle until done (bounded).
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic uns, input int inject);
    logic [W-1:0] eq, er;
    int n, busy_n;
    bit zero_seen;
    model(a, b, uns, eq, er);
    @(negedge clk);
    dif.div_init = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    set_uns(uns);
    @(negedge clk);
    dif.dividend = $urandom;
    dif.divisor  = $urandom;
    set_uns(1'b0);
    n = 1;
    busy_n = 0;
    zero_seen = 0;
    while (dif.done !== 1'b1 && n < 100) begin
      dif.div_init = (n == inject);
      if (n == inject) begin
        dif.dividend = $urandom;
        dif.divisor  = '0;
      end
      if (dif.busy === 1'b1) busy_n++;
      if (dif.div_zero === 1'b1) zero_seen = 1;
      @(negedge clk);
      n++;
    end
    dif.div_init = 1'b0;
    chk({tag, ".done_cycle"}, W'(n), W'(34));
    chk({tag, ".busy_cycles"}, W'(busy_n), W'(33));
    chk({tag, ".busy_at_done"}, W'(dif.busy), W'(0));
    chk({tag, ".no_div_zero"}, W'(zero_seen), W'(0));
    chk({tag, ".lo"}, dif.lo, eq);
    chk({tag, ".hi"}, dif.hi, er);
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, W'(dif.done), W'(0));
  endtask

  initial begin
    int zero_n, busy_n, done_n;
    logic [W-1:0] ra, rb;

    reset = 1'b1;
    dif.div_init = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    set_uns(1'b0);
    repeat (2) @(negedge clk);
    chk("rst.busy", W'(dif.busy), W'(0));
    chk("rst.done", W'(dif.done), W'(0));
    chk("rst.div_zero", W'(dif.div_zero), W'(0));
    chk("rst.hi", dif.hi, '0);
    chk("rst.lo", dif.lo, '0);
    reset = 1'b0;

    run_div("pos", 32'd100, 32'd7, 1'b0, 0);
    chk("pos.lo_const", dif.lo, 32'd14);
    chk("pos.hi_const", dif.hi, 32'd2);
    run_div("negnum", 32'hFFFF_FF9C, 32'd7, 1'b0, 0);
    chk("negnum.lo_const", dif.lo, 32'hFFFF_FFF2);
    chk("negnum.hi_const", dif.hi, 32'hFFFF_FFFE);
    run_div("negden", 32'd100, 32'hFFFF_FFF9, 1'b0, 0);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    chk("ovf.lo_const", dif.lo, 32'h8000_0000);
    chk("ovf.hi_const", dif.hi, 32'h0);
    run_div("minpos", 32'h8000_0000, 32'd1, 1'b0, 0);
    run_div("bigden", 32'd5, 32'h8000_0000, 1'b0, 0);

    // Divide-by-zero after 100/7: flag for one cycle, results retained.
    run_div("pre0", 32'd100, 32'd7, 1'b0, 0);
    @(negedge clk);
    dif.div_init = 1'b1;
    dif.dividend = 32'd55;
    dif.divisor  = 32'd0;
    @(negedge clk);
    dif.div_init = 1'b0;
    chk("dz.flag", W'(dif.div_zero), W'(1));
    zero_n = 0; busy_n = 0; done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (dif.div_zero === 1'b1) zero_n++;
      if (dif.busy === 1'b1) busy_n++;
      if (dif.done === 1'b1) done_n++;
      @(negedge clk);
    end
    chk("dz.flag_cycles", W'(zero_n), W'(1));
    chk("dz.busy_never", W'(busy_n), W'(0));
    chk("dz.done_never", W'(done_n), W'(0));
    chk("dz.hi_kept", dif.hi, 32'd2);
    chk("dz.lo_kept", dif.lo, 32'd14);

    // Reset in the middle of ITER aborts and clears results.
    @(negedge clk);
    dif.div_init = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor  = 32'd3;
    @(negedge clk);
    dif.div_init = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid.busy_before", W'(dif.busy), W'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid.busy", W'(dif.busy), W'(0));
    chk("mid.hi", dif.hi, '0);
    chk("mid.lo", dif.lo, '0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (dif.done === 1'b1) done_n++;
      @(negedge clk);
    end
    chk("mid.done_never", W'(done_n), W'(0));

    // Starts while busy are ignored, including one with a zero divisor.
    run_div("inj1", 32'd1000, 32'd3, 1'b0, 5);
    run_div("inj2", 32'hFFFF_FC18, 32'd3, 1'b0, 33);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = W'($urandom_range(1, 17));
      if (i % 4 == 1) rb = -W'($urandom_range(1, 1000));
      if (rb == '0) rb = 32'd1;
      run_div("rand", ra, rb, 1'b0, (i % 5 == 2) ? 12 : 0);
    end

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    run_div("divu", 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
    chk("divu.lo_const", dif.lo, 32'h7FFF_FFFF);
    chk("divu.hi_const", dif.hi, 32'd1);
    run_div("divs", 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    chk("divs.lo_const", dif.lo, 32'd0);
    chk("divs.hi_const", dif.hi, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == '0) rb = 32'd3;
      run_div("rand_u", ra, rb, 1'b1, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
